sine_wave_loader: RTL and testbench

- Writer side of the FFT sine-table interface.
- Accepts a stream of fixed-point sine samples sin(2*pi*m/N) over a val/rdy handshake and stores them in a register file.
- Drives the full SIZE_FFT-entry sine array plus a table_valid flag consumed by the per-stage twiddle generators.
- Supports reload at runtime, so the table can be swapped without resetting the FFT.

---
 rtl/sine_wave_loader.sv | 132 +++++++++++++
 tb/tb_sine_wave_loader.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sine_wave_loader.sv
// sine_wave_loader
//   Writer side of the FFT sine-table interface. Fixed-point sine samples
//   sin(2*pi*m/N) arrive over a val/rdy handshake and are stored in a
//   register file. The register file drives the full SIZE_FFT-entry sine
//   array and a table_valid flag for the twiddle generators. A one-cycle
//   reload pulse restarts loading without resetting the FFT. Old entries
//   stay visible until they are overwritten.
//
//   Handshake: a sample transfers on a rising edge where recv_val and
//   recv_rdy are both high. recv_rdy is combinational: it is high only in
//   LOAD, with reload low and reset released. recv_val may be asserted at
//   any time. It has no effect while recv_rdy is low.
//
//   Optional feature, macro SINE_WAVE_LOADER_SYMMETRY_EN:
//   Only quadrant samples k=0..N/4 are loaded and stored. The remaining
//   entries are derived by sine symmetry, using a mirror about N/4 and a
//   negated second half. Without the macro, all N samples are loaded and
//   stored directly.
//
// Ports
//   clk           : clock, rising edge
//   reset         : synchronous reset, active low
//   reload        : one-cycle pulse, restarts table loading
//   recv_msg      : sample for the current load index
//   recv_val      : recv_msg valid
//   recv_rdy      : loader accepts a sample this cycle
//   sine_wave_out : [0:SIZE_FFT-1] sine table, entry m = sin(2*pi*m/N)
//   table_valid   : full table loaded and stable
//   dbg_state_o   : FSM state (0 = LOAD, 1 = READY) for checkers

module sine_wave_loader #(
    parameter int BIT_WIDTH  = 32,
    parameter int DECIMAL_PT = 16,
    parameter int SIZE_FFT   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reload,
    input  logic [BIT_WIDTH-1:0] recv_msg,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    output logic [BIT_WIDTH-1:0] sine_wave_out [0:SIZE_FFT-1],
    output logic                 table_valid,
    output logic                 dbg_state_o
);

`ifdef SINE_WAVE_LOADER_SYMMETRY_EN
    localparam int LOAD_COUNT = SIZE_FFT / 4 + 1;
`else
    localparam int LOAD_COUNT = SIZE_FFT;
`endif
    localparam int IDX_W = $clog2(SIZE_FFT) + 1;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 valid_q, valid_d;
    logic [BIT_WIDTH-1:0] store_q [0:LOAD_COUNT-1];
    logic                 hs;

    assign recv_rdy    = (state_q == ST_LOAD) && !reload && reset;
    assign hs          = recv_val && recv_rdy;
    assign table_valid = valid_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (reload) begin
            state_d = ST_LOAD;
            idx_d   = '0;
            valid_d = 1'b0;
        end else if (hs) begin
            // idx stops at LOAD_COUNT-1 on the last sample, so no write can wrap.
            if (idx_q == IDX_W'(LOAD_COUNT - 1)) begin
                state_d = ST_READY;
                valid_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
            valid_q <= 1'b0;
            for (int m = 0; m < LOAD_COUNT; m++) begin
                store_q[m] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            if (hs) begin
                for (int m = 0; m < LOAD_COUNT; m++) begin
                    if (idx_q == IDX_W'(m)) begin
                        store_q[m] <= recv_msg;
                    end
                end
            end
        end
    end

`ifdef SINE_WAVE_LOADER_SYMMETRY_EN
    // Quadrant k maps directly. N/2-k mirrors k. The second half is the
    // negated first half. Negation wraps the most-negative value to itself.
    for (genvar k = 0; k < SIZE_FFT; k++) begin : g_out
        localparam int KH = (k < SIZE_FFT / 2) ? k : k - SIZE_FFT / 2;
        localparam int J  = (KH <= SIZE_FFT / 4) ? KH : SIZE_FFT / 2 - KH;
        if (k < SIZE_FFT / 2) begin : g_pos
            assign sine_wave_out[k] = store_q[J];
        end else begin : g_neg
            assign sine_wave_out[k] = -store_q[J];
        end
    end
`else
    for (genvar k = 0; k < SIZE_FFT; k++) begin : g_out
        assign sine_wave_out[k] = store_q[k];
    end
`endif

    logic unused_param;
    assign unused_param = (DECIMAL_PT < 0);

endmodule

// File: tb/tb_sine_wave_loader.sv
module tb_sine_wave_loader;
  localparam int W  = 32;
  localparam int N  = 8;
`ifdef SINE_WAVE_LOADER_SYMMETRY_EN
  localparam int LC = N / 4 + 1;
`else
  localparam int LC = N;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         reload = 1'b0;
  logic [W-1:0] recv_msg = '0;
  logic         recv_val = 1'b0;
  logic         recv_rdy;
  logic [W-1:0] sine_wave_out [0:N-1];
  logic         table_valid;
  logic         dbg_state_o;

  always #5 clk = ~clk;

  sine_wave_loader #(.BIT_WIDTH(W), .DECIMAL_PT(16), .SIZE_FFT(N)) dut (
    .clk(clk), .reset(reset), .reload(reload), .recv_msg(recv_msg),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .sine_wave_out(sine_wave_out),
    .table_valid(table_valid), .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int failures = 0;

  // Model: samples written in arrival order. A table is "complete" once LC samples are taken.
  logic [W-1:0] m_tab [0:N-1];
  int           m_taken;      // samples accepted since last reset/reload
  bit           m_loading;
  bit           m_valid;
  logic [W-1:0] exp_q[$];     // expected outputs for the current cycle

  logic [W-1:0] sine_ref [0:N-1];
  initial begin
    sine_ref[0] = 32'h00000000; sine_ref[1] = 32'h0000B505;
    sine_ref[2] = 32'h00010000; sine_ref[3] = 32'h0000B505;
    sine_ref[4] = 32'h00000000; sine_ref[5] = 32'hFFFF4AFB;
    sine_ref[6] = 32'hFFFF0000; sine_ref[7] = 32'hFFFF4AFB;
  end

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Value the table should show at entry k given what the model has stored.
  function automatic logic [W-1:0] model_out(input int k);
`ifdef SINE_WAVE_LOADER_SYMMETRY_EN
    int kh;
    kh = k % (N / 2);
    if (kh > N / 4) kh = N / 2 - kh;
    return (k >= N / 2) ? (~m_tab[kh] + 1'b1) : m_tab[kh];
`else
    return m_tab[k];
`endif
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N; k++) m_tab[k] = '0;
    m_taken = 0; m_loading = 1; m_valid = 0;
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, check all outputs, then advance the model.
  task automatic step(input bit rst_n, input bit rl, input bit val, input logic [W-1:0] msg);
    bit exp_rdy;
    @(posedge clk);
    #1;
    reset = rst_n; reload = rl; recv_val = val; recv_msg = msg;
    #2;
    exp_rdy = m_loading && !rl && rst_n;
    exp_q.delete();
    for (int k = 0; k < N; k++) exp_q.push_back(model_out(k));
    check_val("recv_rdy", W'(recv_rdy), W'(exp_rdy));
    check_val("table_valid", W'(table_valid), W'(m_valid));
    check_val("state", W'(dbg_state_o), W'(!m_loading));
    for (int k = 0; k < N; k++) begin
      check_val($sformatf("out[%0d]", k), sine_wave_out[k], exp_q.pop_front());
    end
    if (!rst_n) model_reset();
    else if (rl) begin
      m_taken = 0; m_loading = 1; m_valid = 0;
    end else if (val && m_loading) begin
      m_tab[m_taken] = msg;
      m_taken++;
      if (m_taken == LC) begin
        m_loading = 0; m_valid = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, $urandom);
  endtask

  task automatic check_ref_table(input string tag);
    for (int k = 0; k < N; k++) check_val($sformatf("%s[%0d]", tag, k), sine_wave_out[k], sine_ref[k]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rdy_cycles;
    model_reset();
    // 1. reset then full continuous load
    step(0, 0, 1, 32'h12345678);
    step(0, 0, 1, 32'h12345678);
    rdy_cycles = 0;
    for (int i = 0; i < N; i++) begin
      step(1, 0, 1, sine_ref[i]);
      if (recv_rdy) rdy_cycles++;
    end
    check_val("rdy_cycles", W'(rdy_cycles), W'(LC));
    idle(2);
    check_ref_table("t1");
    check_val("t1_valid", W'(table_valid), W'(1));

    // 2. gapped valid
    step(1, 1, 0, '0);
    for (int i = 0; i < N; i++) begin
      step(1, 0, 1, sine_ref[i]);
      step(1, 0, 0, 32'hBAD0BAD0);
    end
    idle(1);
    check_ref_table("t2");

    // 3. reload after READY, stream a constant
    step(1, 1, 1, 32'h00001111);
    for (int i = 0; i < N + 2; i++) step(1, 0, 1, 32'h00001111);

    // 4. reload colliding with a handshake at idx=3
    step(1, 1, 0, '0);
    for (int i = 0; i < 3 && i < LC - 1; i++) step(1, 0, 1, $urandom);
    step(1, 1, 1, 32'hDEAD0000);
    for (int i = 0; i < N; i++) step(1, 0, 1, sine_ref[i]);
    idle(1);
    check_ref_table("t4");

    // 5. reset mid-load
    step(1, 1, 0, '0);
    for (int i = 0; i < 5 && i < LC - 1; i++) step(1, 0, 1, $urandom);
    step(0, 0, 1, 32'hCAFEF00D);
    for (int i = 0; i < N + 1; i++) step(1, 0, 1, $urandom);

    // random phase
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) != 0, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
